// File: rtl/draw_pkg.sv
// draw_pkg: shared definitions for the draw engine.
//   - command opcodes
//   - FSM state encoding
//   - operand field offsets inside the 256-bit command data word
//   - operand extraction and constant shift-add multiply helpers
package draw_pkg;

  localparam logic [7:0] CMD_FILL_RECT = 8'h01;
  localparam logic [7:0] CMD_CLEAR     = 8'h02;

  localparam int DATA_W    = 256;
  localparam int COORD_W   = 17;  // one bit wider than operands so x0+w cannot wrap
  localparam int X0_OFF    = 0;
  localparam int Y0_OFF    = 16;
  localparam int W_OFF     = 32;
  localparam int H_OFF     = 48;
  localparam int COLOR_OFF = 64;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ROW   = 3'd2,
    ST_REQ   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Pull one 16-bit operand out of the command data word.
  function automatic logic [15:0] get_field(input logic [DATA_W-1:0] d, input logic [7:0] off);
    return d[off +: 16];
  endfunction

  // a * k for a constant k, built from shifted adds so no multiplier is inferred.
  function automatic logic [31:0] mul_const(input logic [15:0] a, input int unsigned k);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (32'(a) << i);
      else      acc = acc;
    end
    return acc;
  endfunction

endpackage

// File: rtl/draw_clip.sv
// draw_clip: combinational clip / validate of a rectangle against the screen.
// Build option: DRAW_ENGINE_CLIP_EN
//   defined   -> rectangle is clipped to [0,SCREEN_W) x [0,SCREEN_H); a fully
//                off-screen rectangle comes out with zero width/height.
//   undefined -> rectangle passes unchanged; reject=1 if it overruns the screen.
// Ports:
//   x0,y0,w,h   in  16  requested rectangle
//   cx,cy,cw,ch out 16  resulting rectangle
//   reject      out 1   rectangle is not drawable
module draw_clip import draw_pkg::*; #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 480
) (
  input  logic [15:0] x0,
  input  logic [15:0] y0,
  input  logic [15:0] w,
  input  logic [15:0] h,
  output logic [15:0] cx,
  output logic [15:0] cy,
  output logic [15:0] cw,
  output logic [15:0] ch,
  output logic        reject
);

  coord_t x_end_s;
  coord_t y_end_s;

  assign x_end_s = coord_t'(x0) + coord_t'(w);
  assign y_end_s = coord_t'(y0) + coord_t'(h);

  // Clip or validate the rectangle extents.
  always_comb begin
    cx     = x0;
    cy     = y0;
    cw     = w;
    ch     = h;
    reject = 1'b0;
`ifdef DRAW_ENGINE_CLIP_EN
    if (coord_t'(x0) >= coord_t'(SCREEN_W)) cw = 16'd0;
    else if (x_end_s > coord_t'(SCREEN_W))  cw = 16'(coord_t'(SCREEN_W) - coord_t'(x0));
    else                                    cw = w;
    if (coord_t'(y0) >= coord_t'(SCREEN_H)) ch = 16'd0;
    else if (y_end_s > coord_t'(SCREEN_H))  ch = 16'(coord_t'(SCREEN_H) - coord_t'(y0));
    else                                    ch = h;
`else
    if ((x_end_s > coord_t'(SCREEN_W)) || (y_end_s > coord_t'(SCREEN_H))) reject = 1'b1;
    else                                                                  reject = 1'b0;
`endif
  end

endmodule

// File: rtl/draw_engine.sv
// draw_engine: rasterises FILL_RECT / CLEAR commands into SDRAM write bursts.
// Each burst is at most MAX_BURST pixels and never crosses a row.
// Build option: DRAW_ENGINE_CLIP_EN (clip instead of reject, see draw_clip).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   command[7:0], data[255:0]    opcode and operands, taken on commit while ack=1
//   commit, bank[1:0]            command valid, target framebuffer bank
//   write_burst_data_req         controller consumed one rgb word
//   write_burst_data_finish      current burst complete
//   write_burst_req              burst request, held until finish
//   rgb, addr, write_burst_len   pixel colour, burst start address, burst length
//   done, err, ack               completion pulse, reject pulse, idle/ready
module draw_engine import draw_pkg::*; #(
  parameter int PIXEL_W    = 16,
  parameter int ADDR_W     = 24,
  parameter int BURST_BITS = 10,
  parameter int MAX_BURST  = 256,
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            command,
  input  logic [DATA_W-1:0]     data,
  input  logic                  commit,
  input  logic [1:0]            bank,
  input  logic                  write_burst_data_req,
  input  logic                  write_burst_data_finish,
  output logic                  write_burst_req,
  output logic [PIXEL_W-1:0]    rgb,
  output logic [ADDR_W-1:0]     addr,
  output logic [BURST_BITS-1:0] write_burst_len,
  output logic                  done,
  output logic                  err,
  output logic                  ack
);

  localparam int RB_W = ADDR_W - 2;

  state_t                state_r, next_state_s;
  logic [7:0]            op_r;
  logic [1:0]            bank_r;
  logic [PIXEL_W-1:0]    color_r;
  logic [15:0]           x0_r, y0_r, w_r, h_r;
  logic [15:0]           clip_x_s, clip_y_s, clip_w_s, clip_h_s;
  logic                  clip_reject_s, bad_op_s, setup_abort_s;
  logic [15:0]           cx_r, cw_r, rows_left_r;
  logic [RB_W-1:0]       row_base_r;
  coord_t                col_r, rem_r;
  logic                  err_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [BURST_BITS-1:0] len_r, beat_cnt_r;
  coord_t                col_after_s, rem_after_s, burst_col_s, burst_rem_s;
  logic [BURST_BITS-1:0] burst_len_s;
  logic [ADDR_W-1:0]     burst_addr_s;

  draw_clip #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clip (
    .x0(x0_r), .y0(y0_r), .w(w_r), .h(h_r),
    .cx(clip_x_s), .cy(clip_y_s), .cw(clip_w_s), .ch(clip_h_s),
    .reject(clip_reject_s)
  );

  assign bad_op_s      = (op_r != CMD_FILL_RECT) && (op_r != CMD_CLEAR);
  assign setup_abort_s = bad_op_s || clip_reject_s || (clip_w_s == 16'd0) || (clip_h_s == 16'd0);

  // Next burst parameters: start of a row in ROW, continuation after a finish otherwise.
  always_comb begin
    col_after_s = col_r + coord_t'(len_r);
    rem_after_s = rem_r - coord_t'(len_r);
    if (state_r == ST_ROW) begin
      burst_col_s = coord_t'(cx_r);
      burst_rem_s = coord_t'(cw_r);
    end else begin
      burst_col_s = col_after_s;
      burst_rem_s = rem_after_s;
    end
    if (burst_rem_s > coord_t'(MAX_BURST)) burst_len_s = BURST_BITS'(MAX_BURST);
    else                                    burst_len_s = BURST_BITS'(burst_rem_s);
    burst_addr_s = {bank_r, row_base_r + RB_W'(burst_col_s)};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  if (commit) next_state_s = ST_SETUP; else next_state_s = ST_IDLE;
      ST_SETUP: if (setup_abort_s) next_state_s = ST_DONE; else next_state_s = ST_ROW;
      ST_ROW:   next_state_s = ST_REQ;
      ST_REQ:   next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (!write_burst_data_finish)       next_state_s = ST_WAIT;
        else if (rem_after_s != coord_t'(0)) next_state_s = ST_REQ;
        else if (rows_left_r > 16'd1)        next_state_s = ST_ROW;
        else                                 next_state_s = ST_DONE;
      end
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Command latch, setup results and per-burst/row datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= 8'd0;
      bank_r      <= 2'd0;
      color_r     <= {PIXEL_W{1'b0}};
      x0_r        <= 16'd0;
      y0_r        <= 16'd0;
      w_r         <= 16'd0;
      h_r         <= 16'd0;
      cx_r        <= 16'd0;
      cw_r        <= 16'd0;
      rows_left_r <= 16'd0;
      row_base_r  <= {RB_W{1'b0}};
      col_r       <= coord_t'(0);
      rem_r       <= coord_t'(0);
      err_r       <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      len_r       <= {BURST_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: if (commit) begin
          op_r    <= command;
          bank_r  <= bank;
          color_r <= data[COLOR_OFF +: PIXEL_W];
          if (command == CMD_CLEAR) begin
            x0_r <= 16'd0;
            y0_r <= 16'd0;
            w_r  <= 16'(SCREEN_W);
            h_r  <= 16'(SCREEN_H);
          end else begin
            x0_r <= get_field(data, 8'(X0_OFF));
            y0_r <= get_field(data, 8'(Y0_OFF));
            w_r  <= get_field(data, 8'(W_OFF));
            h_r  <= get_field(data, 8'(H_OFF));
          end
        end
        ST_SETUP: begin
          cx_r        <= clip_x_s;
          cw_r        <= clip_w_s;
          rows_left_r <= clip_h_s;
          // Only the first row base needs y0*SCREEN_W; later rows accumulate.
          row_base_r  <= RB_W'(mul_const(clip_y_s, SCREEN_W));
          err_r       <= bad_op_s || clip_reject_s;
        end
        ST_ROW: begin
          col_r  <= burst_col_s;
          rem_r  <= burst_rem_s;
          addr_r <= burst_addr_s;
          len_r  <= burst_len_s;
        end
        ST_WAIT: if (write_burst_data_finish) begin
          if (rem_after_s != coord_t'(0)) begin
            col_r  <= burst_col_s;
            rem_r  <= burst_rem_s;
            addr_r <= burst_addr_s;
            len_r  <= burst_len_s;
          end else begin
            rows_left_r <= rows_left_r - 16'd1;
            row_base_r  <= row_base_r + RB_W'(SCREEN_W);
          end
        end
        default: ;
      endcase
    end
  end

  // Beats taken in the current burst; saturates at the burst length so extra beats are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_cnt_r <= {BURST_BITS{1'b0}};
    else if ((state_r == ST_ROW) || ((state_r == ST_WAIT) && write_burst_data_finish))
      beat_cnt_r <= {BURST_BITS{1'b0}};
    else if (write_burst_req && write_burst_data_req && (beat_cnt_r < len_r))
      beat_cnt_r <= beat_cnt_r + {{(BURST_BITS-1){1'b0}}, 1'b1};
  end

  assign ack             = (state_r == ST_IDLE);
  assign write_burst_req = (state_r == ST_REQ) || (state_r == ST_WAIT);
  assign done            = (state_r == ST_DONE);
  assign err             = (state_r == ST_DONE) && err_r;
  assign rgb             = (state_r == ST_IDLE) ? {PIXEL_W{1'b0}} : color_r;
  assign addr            = addr_r;
  assign write_burst_len = len_r;

endmodule

// File: tb/tb_draw_engine.sv
`timescale 1ns/1ps
module tb_draw_engine;

  localparam int SW = 800;
  localparam int SH = 480;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   command;
  logic [255:0] data;
  logic         commit;
  logic [1:0]   bank;
  logic         write_burst_data_req;
  logic         write_burst_data_finish;
  logic         write_burst_req;
  logic [15:0]  rgb;
  logic [23:0]  addr;
  logic [9:0]   write_burst_len;
  logic         done, err, ack;

  typedef struct packed { logic [23:0] addr; logic [9:0] len; } burst_t;
  burst_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          beat_cap = 1024;
  int          extra_beats = 0;
  logic [15:0] exp_color = 16'h0000;

  draw_engine dut (
    .clk(clk), .rst_n(rst_n), .command(command), .data(data), .commit(commit),
    .bank(bank), .write_burst_data_req(write_burst_data_req),
    .write_burst_data_finish(write_burst_data_finish), .write_burst_req(write_burst_req),
    .rgb(rgb), .addr(addr), .write_burst_len(write_burst_len),
    .done(done), .err(err), .ack(ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int x, input int y, input int w, input int h,
                                      input logic [15:0] c);
    logic [255:0] d;
    d = {256{1'b1}};
    d[15:0]  = 16'(x);
    d[31:16] = 16'(y);
    d[47:32] = 16'(w);
    d[63:48] = 16'(h);
    d[79:64] = c;
    return d;
  endfunction

  // Reference burst list: rows split into chunks of at most 256 pixels.
  task automatic push_rect(input int x, input int y, input int w, input int h, input logic [1:0] bk);
    for (int r = 0; r < h; r++) begin
      int c;
      c = 0;
      while (c < w) begin
        int l;
        burst_t e;
        l = ((w - c) > 256) ? 256 : (w - c);
        e.addr = {bk, 22'((y + r) * SW + x + c)};
        e.len  = 10'(l);
        exp_q.push_back(e);
        c += l;
      end
    end
  endtask

  task automatic commit_cmd(input logic [7:0] op, input logic [255:0] d, input logic [1:0] bk);
    @(negedge clk);
    command = op;
    data    = d;
    bank    = bk;
    commit  = 1'b1;
    @(posedge clk);
    #1;
    commit  = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (write_burst_req !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("req_seen", 64'(write_burst_req), 64'd1);
  endtask

  task automatic wait_done(input logic exp_err, input int budget, output int cycles);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    cycles = n;
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("err_with_done", 64'(err), 64'(exp_err));
      check("bursts_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("ack_after_done", 64'(ack), 64'd1);
    end else begin
      exp_q.delete();
    end
  endtask

  // Burst controller model and scoreboard consumer.
  initial begin
    burst_t e;
    int     n;
    write_burst_data_req    = 1'b0;
    write_burst_data_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && write_burst_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("burst_expected", 64'(exp_q.size() != 0), 64'd1);
          n = 1;
        end else begin
          e = exp_q.pop_front();
          check("burst_addr", 64'(addr), 64'(e.addr));
          check("burst_len", 64'(write_burst_len), 64'(e.len));
          n = ((int'(e.len) < beat_cap) ? int'(e.len) : beat_cap) + extra_beats;
        end
        for (int b = 0; b < n && rst_n === 1'b1; b++) begin
          write_burst_data_req = 1'b1;
          @(negedge clk);
        end
        write_burst_data_req = 1'b0;
        if (rst_n === 1'b1) begin
          check("rgb_in_burst", 64'(rgb), 64'(exp_color));
          write_burst_data_finish = 1'b1;
          @(negedge clk);
          write_burst_data_finish = 1'b0;
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int cyc;
    int dc0;
    rst_n   = 1'b0;
    commit  = 1'b0;
    command = 8'h00;
    data    = '0;
    bank    = 2'd0;
    #12;
    check("rst_req", 64'(write_burst_req), 64'd0);
    check("rst_rgb", 64'(rgb), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_len", 64'(write_burst_len), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ack", 64'(ack), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill rectangle spanning two bursts per row, with excess beats.
    exp_color = 16'hF800;
    extra_beats = 2;
    push_rect(10, 2, 300, 2, 2'd1);
    dc0 = done_cnt;
    commit_cmd(8'h01, mk(10, 2, 300, 2, 16'hF800), 2'd1);
    check("ack_drop", 64'(ack), 64'd0);
    check("req_setup", 64'(write_burst_req), 64'd0);
    @(posedge clk); #1;
    check("req_row", 64'(write_burst_req), 64'd0);
    @(posedge clk); #1;
    check("first_req_latency", 64'(write_burst_req), 64'd1);
    check("first_addr", 64'(addr), 64'h40064A);
    wait_done(1'b0, 5000, cyc);
    check("single_done", 64'(done_cnt - dc0), 64'd1);
    extra_beats = 0;

    // Commit pulsed mid-burst must be ignored.
    exp_color = 16'h07E0;
    push_rect(100, 50, 600, 1, 2'd2);
    commit_cmd(8'h01, mk(100, 50, 600, 1, 16'h07E0), 2'd2);
    wait_req(10);
    @(negedge clk);
    command = 8'h02;
    data    = mk(0, 0, 5, 5, 16'h1234);
    commit  = 1'b1;
    @(posedge clk); #1;
    commit  = 1'b0;
    check("busy_ack", 64'(ack), 64'd0);
    check("busy_rgb", 64'(rgb), 64'h07E0);
    wait_done(1'b0, 5000, cyc);
    repeat (5) @(posedge clk);
    #1;
    check("no_queued_cmd", 64'(write_burst_req), 64'd0);

    // Zero width: no request, done two cycles after commit, no err.
    commit_cmd(8'h01, mk(5, 5, 0, 4, 16'hAAAA), 2'd0);
    wait_done(1'b0, 10, cyc);
    check("zero_area_latency", 64'(cyc), 64'd1);

    // Unknown opcode.
    commit_cmd(8'h7F, mk(1, 1, 1, 1, 16'h5555), 2'd0);
    wait_done(1'b1, 10, cyc);
    check("bad_op_latency", 64'(cyc), 64'd1);

    // Rectangle overrunning the right edge.
    exp_color = 16'h001F;
`ifdef DRAW_ENGINE_CLIP_EN
    push_rect(700, 0, 100, 1, 2'd0);
    commit_cmd(8'h01, mk(700, 0, 200, 1, 16'h001F), 2'd0);
    wait_done(1'b0, 1000, cyc);
`else
    commit_cmd(8'h01, mk(700, 0, 200, 1, 16'h001F), 2'd0);
    wait_done(1'b1, 10, cyc);
    check("reject_latency", 64'(cyc), 64'd1);
`endif

    // Reset while waiting for a burst to finish.
    exp_color = 16'hBEEF;
    push_rect(0, 10, 600, 3, 2'd3);
    commit_cmd(8'h01, mk(0, 10, 600, 3, 16'hBEEF), 2'd3);
    wait_req(10);
    @(negedge clk);
    @(negedge clk);
    #2;
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_req", 64'(write_burst_req), 64'd0);
    check("arst_ack", 64'(ack), 64'd1);
    check("arst_rgb", 64'(rgb), 64'd0);
    check("arst_addr", 64'(addr), 64'd0);
    check("arst_len", 64'(write_burst_len), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_cnt - dc0), 64'd0);
    exp_color = 16'h0F0F;
    push_rect(20, 400, 40, 2, 2'd1);
    commit_cmd(8'h01, mk(20, 400, 40, 2, 16'h0F0F), 2'd1);
    wait_done(1'b0, 1000, cyc);

    // Full-screen clear, short beat runs to keep the run brief.
    exp_color = 16'h0000;
    beat_cap = 2;
    push_rect(0, 0, SW, SH, 2'd0);
    check("clear_burst_count", 64'(exp_q.size()), 64'd1920);
    commit_cmd(8'h02, mk(5, 5, 1, 1, 16'h0000), 2'd0);
    wait_done(1'b0, 40000, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_engine.md
# draw_engine

Parametrised successor to the single-mode rectangle drawer in the graphics pipeline. It accepts a draw command from the command front-end via a commit/ack handshake and rasterises it into a framebuffer bank. The output is a sequence of SDRAM write bursts, each at most `MAX_BURST` pixels and never crossing a row. It supports rectangle fill and full-screen clear, configurable screen geometry, and optional clipping.

## Interface
- `PIXEL_W`, 16, pixel width in bits.
- `ADDR_W`, 24, SDRAM word address width; top 2 bits are the bank.
- `BURST_BITS`, 10, width of `write_burst_len`.
- `MAX_BURST`, 256, maximum pixels per burst; must be ≤ 2^BURST_BITS−1.
- `SCREEN_W`, 800 / `SCREEN_H`, 480, framebuffer geometry in pixels.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `command` in 8: opcode.
- `data` in 256: operands. x0=[15:0], y0=[31:16], w=[47:32], h=[63:48], color=[64+PIXEL_W-1:64].
- `commit` in 1: command valid; accepted only while `ack`=1.
- `bank` in 2: target framebuffer; sampled at commit.
- `write_burst_data_req` in 1: controller consumes one `rgb` word this cycle.
- `write_burst_data_finish` in 1: current burst complete.
- `write_burst_req` out 1: burst request.
- `rgb` out PIXEL_W: pixel data.
- `addr` out ADDR_W: burst start address.
- `write_burst_len` out BURST_BITS: burst length.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse with `done` when a command is rejected.
- `ack` out 1: 1 when idle, able to accept `commit`.

## Operation
- Opcodes:
  - `CMD_FILL_RECT`=8'h01.
  - `CMD_CLEAR`=8'h02: uses x0=0, y0=0, w=SCREEN_W, h=SCREEN_H; ignores data operands except color.
  - Any other opcode: accepted, no bursts, `done`+`err`.
- FSM states and transitions:
  - IDLE: `ack`=1; commit latches opcode, operands and bank, then goes to SETUP.
  - SETUP: clip or validate, then go to ROW. If w=0, h=0, or the command is rejected, go to DONE.
  - ROW: row base = y·SCREEN_W, computed by accumulating SCREEN_W per row (no multiplier). Column cursor = x0; remaining = w.
  - REQ: assert `write_burst_req`; `write_burst_len` = min(remaining, MAX_BURST).
  - WAIT: hold `write_burst_req` high until `write_burst_data_finish`. On finish: advance cursor, remaining −= len. If remaining>0 go to REQ; else if rows remain go to ROW; else go to DONE.
  - DONE: pulse `done` (and `err` if rejected), then IDLE.
- `addr` = {bank, (rowbase + col)[ADDR_W-3:0]}; held stable while `write_burst_req`=1.
- `rgb` = latched color whenever busy; don't-care in IDLE, driven 0.
- Beat counter: counts `write_burst_data_req` per burst. Excess beats are ignored; `rgb` stays the fill color.
- `commit` while busy is ignored; the command is not queued.
- `write_burst_data_finish` outside WAIT is ignored.
- Coordinate arithmetic is 17-bit to avoid wrap on x0+w and y0+h.

## Timing
- Reset values: `write_burst_req`=0, `rgb`=0, `addr`=0, `write_burst_len`=0, `done`=0, `err`=0, `ack`=1; FSM in IDLE.
- Commit accepted at edge N; `ack`=0 from N+1.
- First `write_burst_req` is high at N+3 (SETUP, ROW, REQ).
- Next `write_burst_req` is high 1 cycle after finish within a row, or 2 cycles after finish at a row change.
- `done` is high exactly 1 cycle, 1 cycle after the last finish. `ack`=1 the following cycle.
- Zero-area or rejected command: `done` at N+2, no request.
- Reset mid-operation: all outputs return to reset values immediately. No `done` is issued and the command is lost.

## Configuration
- `DRAW_ENGINE_CLIP_EN` defined: rectangles are clipped to [0,SCREEN_W)×[0,SCREEN_H). A fully off-screen rectangle becomes zero-area: `done` without `err`.
- Not defined: any rectangle with x0+w>SCREEN_W or y0+h>SCREEN_H is rejected with `done`+`err` and no writes.

## Structure
- Package `draw_pkg` holds:
  - opcode constants;
  - FSM state enum;
  - operand field offsets;
  - the `data` field extraction helper.
- Sub-module `draw_clip`: combinational clip/validate of (x0,y0,w,h), producing the clipped rectangle and a reject flag. It is registered in SETUP.

## Test plan
- FILL_RECT x=10,y=2,w=300,h=2,color=16'hF800,bank=1 -> four bursts, addr low bits 1610/1866/2410/2666, len 256/44/256/44, `rgb`=F800, single `done`.
- CLEAR bank 0 color 0 -> 1920 bursts: each row 256,256,256,32. First addr 0, last addr 383968 len 32, then `done`.
- x=700,w=200,y=0,h=1 -> with CLIP_EN: one burst addr 700 len 100. Without: no burst, `done`+`err` at N+2.
- w=0 -> no `write_burst_req`, `done` at N+2, `err`=0. Opcode 8'h7F -> `done`+`err`.
- `commit` pulsed mid-burst -> ignored; outputs and burst sequence unchanged.
- `rst_n` low during WAIT -> `write_burst_req`=0, `ack`=1 asynchronously; no `done`; a fresh command works afterwards.
